// File: rtl/bcd_conv_sched_if.sv
// Request/result bundle between requesters and the shared BCD converter.
// Requesters hold req/bin_in until their gnt bit pulses; results arrive with a done pulse.
interface bcd_conv_sched_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1,
    parameter int NBIT = 16
);
    logic [NREQ-1:0]            req;
    logic [NREQ*(NBIT+1)-1:0]   bin_in;
    logic [NREQ-1:0]            gnt;
    logic                       busy;
    logic                       done;
    logic [IDW-1:0]             done_id;
    logic [16:0]                bcd_out;
    logic                       ovf;

    modport master (
        output req, bin_in,
        input  gnt, busy, done, done_id, bcd_out, ovf
    );

    modport slave (
        input  req, bin_in,
        output gnt, busy, done, done_id, bcd_out, ovf
    );
endinterface

// File: rtl/bcd_conv_sched.sv
// Round-robin shared binary-to-BCD engine; done 17 edges after capture, one issue per 18 cycles.
// req is level and held until gnt, ignored while busy; BCD_SAT_EN clamps overflowed digits to 9999.
module bcd_conv_sched #(
    parameter int NREQ = 2,
    parameter int IDW  = 1,
    parameter int NBIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_conv_sched_if.slave bus
);
    localparam int OPW = NBIT + 1;
    localparam int CW  = $clog2(NBIT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  done_id_q, done_id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [19:0]     scr_q, scr_d;
    logic [NBIT-1:0] mag_q, mag_d;
    logic            sign_q, sign_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic [16:0]     bcd_q, bcd_d;

    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  cand;
    logic [OPW-1:0]  op_sel;
    logic [NREQ-1:0] win_oh;
    logic [19:0]     scr_adj;

    // Scan from the highest offset down so the candidate nearest the pointer wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (int'(ptr_q) + i >= NREQ) begin
                cand = IDW'(int'(ptr_q) + i - NREQ);
            end else begin
                cand = IDW'(int'(ptr_q) + i);
            end
            if (bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        op_sel = '0;
        win_oh = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == IDW'(k)) begin
                op_sel    = bus.bin_in[k*OPW +: OPW];
                win_oh[k] = found;
            end
        end
    end

    always_comb begin
        scr_adj = '0;
        for (int k = 0; k < 5; k++) begin
            scr_adj[4*k +: 4] = (scr_q[4*k +: 4] >= 4'd5) ? scr_q[4*k +: 4] + 4'd3
                                                            : scr_q[4*k +: 4];
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        done_id_d = done_id_q;
        cnt_d     = cnt_q;
        scr_d     = scr_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        gnt_d     = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                busy_d = found;
                if (found) begin
                    sign_d  = op_sel[OPW-1];
                    mag_d   = op_sel[NBIT-1:0];
                    id_d    = win;
                    cnt_d   = CW'(NBIT);
                    scr_d   = '0;
                    gnt_d   = win_oh;
                    ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, mag_d} = {scr_adj[18:0], mag_q, 1'b0};
                cnt_d          = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ovf_d     = |scr_q[19:16];
                bcd_d     = {sign_q, scr_q[15:0]};
`ifdef BCD_SAT_EN
                if (|scr_q[19:16]) begin
                    bcd_d[15:0] = 16'h9999;
                end
`endif
                done_d    = 1'b1;
                done_id_d = id_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            done_id_q <= '0;
            cnt_q     <= '0;
            scr_q     <= '0;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            done_id_q <= done_id_d;
            cnt_q     <= cnt_d;
            scr_q     <= scr_d;
            mag_q     <= mag_d;
            sign_q    <= sign_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.bcd_out = bcd_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Randomized scoreboard bench for bcd_conv_sched against a decimal-arithmetic reference.
// Expected results are queued at each predicted grant and compared when done is predicted.
module tb_bcd_conv_sched;
    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam int NBIT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_conv_sched_if #(.NREQ(NREQ), .IDW(IDW), .NBIT(NBIT)) bus ();

    bcd_conv_sched #(.NREQ(NREQ), .IDW(IDW), .NBIT(NBIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;
    int exp_q[$];

    logic [NREQ-1:0]    req_prev  = '0;
    logic [NREQ*17-1:0] bin_prev  = '0;
    logic               rst_prev  = 1'b0;
    int                 ptr       = 0;
    bit                 inflight  = 1'b0;
    bit                 idle_next = 1'b1;
    int                 cyc       = 0;
    int                 gnt_cyc   = 0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain decimal arithmetic; packed as {ovf, sign, 4 BCD digits}.
    function automatic int ref_conv(int op);
        int m, lo, r;
        bit ov;
        m  = op & 'hFFFF;
        ov = (m > 9999);
        lo = m % 10000;
        r  = (lo / 1000) * 4096 + ((lo / 100) % 10) * 256 + ((lo / 10) % 10) * 16 + lo % 10;
`ifdef BCD_SAT_EN
        if (ov) r = 'h9999;
`endif
        return (int'(ov) << 17) | (op & 'h10000) | r;
    endfunction

    always @(negedge clk) begin
        int  exp_g, w, e;
        bit  exp_done;
        cyc++;
        if (!rst_prev) begin
            chk("rst_gnt",     int'(bus.gnt),     0);
            chk("rst_busy",    int'(bus.busy),    0);
            chk("rst_done",    int'(bus.done),    0);
            chk("rst_done_id", int'(bus.done_id), 0);
            chk("rst_bcd_out", int'(bus.bcd_out), 0);
            chk("rst_ovf",     int'(bus.ovf),     0);
            exp_q.delete();
            ptr       = 0;
            inflight  = 1'b0;
            idle_next = 1'b1;
        end else begin
            exp_g = 0;
            if (idle_next && req_prev != '0) begin
                w = -1;
                for (int i = 0; i < NREQ; i++) begin
                    int j;
                    j = (ptr + i) % NREQ;
                    if (w < 0 && req_prev[j]) w = j;
                end
                exp_g = 1 << w;
                exp_q.push_back((w << 18) | ref_conv(int'(bin_prev[17*w +: 17])));
                ptr      = (w + 1) % NREQ;
                inflight = 1'b1;
                gnt_cyc  = cyc;
            end
            chk("gnt", int'(bus.gnt), exp_g);
            exp_done = inflight && (cyc - gnt_cyc == 17);
            chk("done", int'(bus.done), int'(exp_done));
            if (exp_done && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("done_id", int'(bus.done_id), e >> 18);
                chk("bcd_out", int'(bus.bcd_out), e & 'h1FFFF);
                chk("ovf",     int'(bus.ovf),     (e >> 17) & 1);
            end
            chk("busy", int'(bus.busy), int'(inflight));
            idle_next = !inflight || exp_done;
            if (exp_done) inflight = 1'b0;
        end
        req_prev = bus.req;
        bin_prev = bus.bin_in;
        rst_prev = rst_n;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic request(int k, logic [16:0] v);
        int t;
        bus.bin_in[17*k +: 17] = v;
        bus.req[k] = 1'b1;
        t = 0;
        do begin
            tick(1);
            t++;
        end while (!bus.gnt[k] && t < 100);
        chk("gnt_wait", int'(bus.gnt[k]), 1);
        bus.req[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.busy && t < 100) begin
            tick(1);
            t++;
        end
        chk("idle_wait", int'(bus.busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    logic [16:0] corner_v [6];

    initial begin
        corner_v = '{17'h00000, 17'h10000, 17'h0270F, 17'h02710, 17'h1FFFF, 17'h0FFFF};
        bus.req    = '0;
        bus.bin_in = '0;
        rst_n      = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        request(0, 17'h004D2);
        wait_idle();
        request(1, 17'h1270F);
        request(1, 17'h00000);
        request(0, 17'h0FFFF);
        request(0, 17'h10000);
        wait_idle();

        do_reset();
        bus.bin_in[0 +: 17]  = 17'h00123;
        bus.bin_in[17 +: 17] = 17'h1F00D;
        bus.req = 2'b11;
        tick(75);
        bus.req = '0;
        wait_idle();

        request(0, 17'h0BEEF);
        tick(8);
        do_reset();
        request(1, 17'h01F40);
        tick(3);
        bus.bin_in[0 +: 17] = 17'h00777;
        bus.req[0] = 1'b1;
        tick(1);
        bus.req[0] = 1'b0;
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                if ($urandom_range(0, 2) == 0)
                    bus.bin_in[17*k +: 17] = corner_v[$urandom_range(0, 5)];
                else
                    bus.bin_in[17*k +: 17] = 17'($urandom);
            end
            bus.req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            tick($urandom_range(1, 25));
        end
        bus.req = '0;
        wait_idle();
        tick(2);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
